pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage forwarding pipeline. Merges the

---
 rtl/pipeline_stall_controller.sv | 162 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central stall/flush sequencer for the 5-stage forwarding pipeline. Merges
//   the ID-stage load-use hazard, the EXE-stage branch-taken flag and the
//   MEM-stage SRAM handshake into per-stage freeze/bubble/flush controls.
//   It detects SRAM timeouts and keeps saturating performance counters.
//
// Parameters
//   MEM_TIMEOUT  max extra SRAM wait cycles tolerated before ERROR (>=1)
//   CNT_W        width of each performance counter
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   hazard_detected  load-use hazard (ID)
//   br_taken         branch/jump taken (EXE)
//   mem_req          MEM-stage instruction accesses SRAM (level)
//   sram_ready       SRAM op completes this cycle
//   perf_clr         synchronous clear of all counters
//   freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
//   freeze_id_exe, freeze_exe_mem, bubble_mem_wb   pipeline controls
//   mem_timeout      sticky SRAM timeout; pipeline stays frozen until rst
//   lu_stall_cnt, flush_cnt, mem_stall_cnt         performance counters
//   state_dbg        current FSM state (0=RUN, 1=MEM_WAIT, 2=ERROR)
//
// Handshake: the SRAM side is a level protocol. While mem_req is high, the
// access completes in the first cycle with sram_ready=1. Every cycle before
// that one is a stall cycle.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             perf_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             bubble_mem_wb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [1:0]       state_dbg
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] lu_q, fl_q, ms_q;

  logic in_err, mem_stall, br_act, hz_act;
  logic lu_inc, fl_inc, ms_inc;

  always_comb begin
    in_err    = (state == ERROR);
    mem_stall = ((state == RUN) && mem_req && !sram_ready) ||
                ((state == MEM_WAIT) && !sram_ready);
    // Branch and hazard only act when the pipeline is not frozen. A hazard
    // that arrives together with a branch is dropped, because the branch
    // flushes the instruction that raised it.
    br_act    = !in_err && !mem_stall && br_taken;
    hz_act    = !in_err && !mem_stall && !br_taken && hazard_detected;
    // In ERROR the branch and hazard counters still track their raw
    // conditions. The memory stall counter stops counting.
    lu_inc    = in_err ? (hazard_detected && !br_taken) : hz_act;
    fl_inc    = in_err ? br_taken : br_act;
    ms_inc    = mem_stall;
  end

  // Controls are combinational from state and inputs. All outputs read
  // zero while reset is held.
  always_comb begin
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    flush_if_id    = 1'b0;
    bubble_id_exe  = 1'b0;
    freeze_id_exe  = 1'b0;
    freeze_exe_mem = 1'b0;
    bubble_mem_wb  = 1'b0;
    mem_timeout    = 1'b0;
    lu_stall_cnt   = '0;
    flush_cnt      = '0;
    mem_stall_cnt  = '0;
    state_dbg      = 2'd0;
    if (!rst) begin
      lu_stall_cnt  = lu_q;
      flush_cnt     = fl_q;
      mem_stall_cnt = ms_q;
      state_dbg     = state;
      if (in_err || mem_stall) begin
        freeze_pc      = 1'b1;
        freeze_if_id   = 1'b1;
        freeze_id_exe  = 1'b1;
        freeze_exe_mem = 1'b1;
        bubble_mem_wb  = 1'b1;
        mem_timeout    = in_err;
      end else if (br_act) begin
        flush_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
      end else if (hz_act) begin
        freeze_pc     = 1'b1;
        freeze_if_id  = 1'b1;
        bubble_id_exe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !sram_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        MEM_WAIT: begin
          // A ready in the last allowed cycle still completes the access.
          if (sram_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= ERROR;
      endcase
    end
  end

  // Counters saturate at all-ones. A clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      lu_q <= '0;
      fl_q <= '0;
      ms_q <= '0;
    end else begin
      if (lu_inc && !(&lu_q)) lu_q <= lu_q + CNT_W'(1);
      if (fl_inc && !(&fl_q)) fl_q <= fl_q + CNT_W'(1);
      if (ms_inc && !(&ms_q)) ms_q <= ms_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  localparam int CW = 2;

  // Control order: {fpc, fifid, flush, bub_ide, fide, fem, bmw, mto}
  localparam logic [7:0] C0 = 8'b0000_0000;
  localparam logic [7:0] HZ = 8'b1101_0000;
  localparam logic [7:0] BR = 8'b0011_0000;
  localparam logic [7:0] MS = 8'b1100_1110;
  localparam logic [7:0] ER = 8'b1100_1111;

  logic clk = 1'b0;
  logic rst, hazard_detected, br_taken, mem_req, sram_ready, perf_clr;
  logic freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe;
  logic freeze_id_exe, freeze_exe_mem, bubble_mem_wb, mem_timeout;
  logic [CW-1:0] lu_stall_cnt, flush_cnt, mem_stall_cnt;
  logic [1:0] state_dbg;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int checks = 0;
  int failures = 0;

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard_detected), .br_taken(br_taken),
    .mem_req(mem_req), .sram_ready(sram_ready), .perf_clr(perf_clr),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .bubble_id_exe(bubble_id_exe),
    .freeze_id_exe(freeze_id_exe), .freeze_exe_mem(freeze_exe_mem),
    .bubble_mem_wb(bubble_mem_wb), .mem_timeout(mem_timeout),
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt),
    .mem_stall_cnt(mem_stall_cnt), .state_dbg(state_dbg)
  );

  function automatic logic [15:0] mk(input logic [7:0] c, input logic [1:0] st,
                                     input logic [1:0] lu, input logic [1:0] fl,
                                     input logic [1:0] ms);
    return {c, st, lu, fl, ms};
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs just after the rising edge and queues the
  // response expected during that cycle.
  task automatic step(input string nm, input logic r, input logic hz,
                      input logic br, input logic mq, input logic sr,
                      input logic pc, input logic [15:0] e);
    @(posedge clk);
    #1;
    rst = r; hazard_detected = hz; br_taken = br;
    mem_req = mq; sram_ready = sr; perf_clr = pc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] act, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
             freeze_id_exe, freeze_exe_mem, bubble_mem_wb, mem_timeout,
             state_dbg, lu_stall_cnt, flush_cnt, mem_stall_cnt};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got ctrl=%b st=%0d lu=%0d fl=%0d ms=%0d, expected ctrl=%b st=%0d lu=%0d fl=%0d ms=%0d",
                 nm, act[15:8], act[7:6], act[5:4], act[3:2], act[1:0],
                 e[15:8], e[7:6], e[5:4], e[3:2], e[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst = 1'b1; hazard_detected = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; sram_ready = 1'b0; perf_clr = 1'b0;

    //           name            rst hz br mq sr clr  expected
    step("reset0",        1, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 0));
    step("reset1",        1, 1, 1, 1, 0, 0, mk(C0, 0, 0, 0, 0));
    step("idle",          0, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 0));
    // load-use hazard alone
    step("hazard",        0, 1, 0, 0, 0, 0, mk(HZ, 0, 0, 0, 0));
    step("hazard_cnt",    0, 0, 0, 0, 0, 0, mk(C0, 0, 1, 0, 0));
    // branch wins over hazard
    step("br_and_hz",     0, 1, 1, 0, 0, 0, mk(BR, 0, 1, 0, 0));
    step("br_cnt",        0, 0, 0, 0, 0, 0, mk(C0, 0, 1, 1, 0));
    step("clr",           0, 0, 0, 0, 0, 1, mk(C0, 0, 1, 1, 0));
    // SRAM ready on third cycle
    step("mem_c0",        0, 0, 0, 1, 0, 0, mk(MS, 0, 0, 0, 0));
    step("mem_c1",        0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 1));
    step("mem_c2_ready",  0, 0, 0, 1, 1, 0, mk(C0, 1, 0, 0, 2));
    step("mem_done",      0, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 2));
    // branch held through a 2-cycle stall
    step("mem_br_c0",     0, 0, 1, 1, 0, 0, mk(MS, 0, 0, 0, 2));
    step("mem_br_c1",     0, 0, 1, 1, 0, 0, mk(MS, 1, 0, 0, 3));
    step("mem_br_flush",  0, 0, 1, 1, 1, 0, mk(BR, 1, 0, 0, 3));
    step("after_flush",   0, 0, 0, 0, 0, 0, mk(C0, 0, 0, 1, 3));
    // zero-wait access never stalls
    step("zero_wait_hz",  0, 1, 0, 1, 1, 0, mk(HZ, 0, 0, 1, 3));
    // saturation and clear-beats-increment
    step("clr_with_hz",   0, 1, 0, 0, 0, 1, mk(HZ, 0, 1, 1, 3));
    step("sat_hz1",       0, 1, 0, 0, 0, 0, mk(HZ, 0, 0, 0, 0));
    step("sat_hz2",       0, 1, 0, 0, 0, 0, mk(HZ, 0, 1, 0, 0));
    step("sat_hz3",       0, 1, 0, 0, 0, 0, mk(HZ, 0, 2, 0, 0));
    step("sat_hz4",       0, 1, 0, 0, 0, 0, mk(HZ, 0, 3, 0, 0));
    step("sat_hz5",       0, 1, 0, 0, 0, 0, mk(HZ, 0, 3, 0, 0));
    step("sat_hold",      0, 0, 0, 0, 0, 0, mk(C0, 0, 3, 0, 0));
    step("clr2",          0, 0, 0, 0, 0, 1, mk(C0, 0, 3, 0, 0));
    step("cleared",       0, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 0));
    // ready in the last allowed cycle beats the timeout
    step("last_c0",       0, 0, 0, 1, 0, 0, mk(MS, 0, 0, 0, 0));
    step("last_c1",       0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 1));
    step("last_c2",       0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 2));
    step("last_c3",       0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 3));
    step("last_c4_ready", 0, 0, 0, 1, 1, 0, mk(C0, 1, 0, 0, 3));
    step("last_done",     0, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 3));
    step("clr3",          0, 0, 0, 0, 0, 1, mk(C0, 0, 0, 0, 3));
    // SRAM never ready -> sticky timeout
    step("to_c0",         0, 0, 0, 1, 0, 0, mk(MS, 0, 0, 0, 0));
    step("to_c1",         0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 1));
    step("to_c2",         0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 2));
    step("to_c3",         0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 3));
    step("to_c4",         0, 0, 0, 1, 0, 0, mk(MS, 1, 0, 0, 3));
    step("to_c5_error",   0, 0, 0, 1, 0, 0, mk(ER, 2, 0, 0, 3));
    step("error_ready",   0, 0, 0, 0, 1, 0, mk(ER, 2, 0, 0, 3));
    step("error_held",    0, 0, 0, 0, 0, 0, mk(ER, 2, 0, 0, 3));
    step("error_rst",     1, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 0));
    step("post_rst",      0, 0, 0, 0, 0, 0, mk(C0, 0, 0, 0, 0));

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
